// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if
// Bundles the game-round controller's stimulus and result signals.
//   start     : level start request; a rising edge starts a game
//   box_in    : 2-bit box index from the LFSR-to-box mapper
//   hit       : per-box hit inputs, level, synchronous to clk
//   box_led   : one-hot lit box, 0 when no box is armed
//   score     : correct hits this game (saturating)
//   misses    : timeouts plus wrong-box hits this game (saturating)
//   round_num : rounds completed this game
//   hit_ok    : one-cycle pulse on a correct hit
//   miss      : one-cycle pulse on a timeout or wrong hit
//   done      : high while the game is over, until the next start
// master: the side driving start/box_in/hit (mapper, buttons, bench).
// slave : the round controller.
interface mole_round_ctrl_if;
  logic       start;
  logic [1:0] box_in;
  logic [3:0] hit;
  logic [3:0] box_led;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] round_num;
  logic       hit_ok;
  logic       miss;
  logic       done;

  modport master (
    output start, box_in, hit,
    input  box_led, score, misses, round_num, hit_ok, miss, done
  );

  modport slave (
    input  start, box_in, hit,
    output box_led, score, misses, round_num, hit_ok, miss, done
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl
// Whack-a-mole round controller. Each round it waits a dark gap, latches one
// box from the mapper, lights it and waits a bounded time for a hit on it.
// Keeps score / miss / round counters for the display logic.
//
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset (released synchronously inside)
//   bus    : mole_round_ctrl_if.slave (start, box_in, hit in;
//            box_led, score, misses, round_num, hit_ok, miss, done out)
//
// Optional build macro MOLE_NO_REPEAT_EN: when defined, a box equal to the
// previous round's box is bumped to (box+1) mod 4 at arm time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | after reset, waiting for a start edge
// S_GAP    | all boxes dark, gap counter running
// S_ARMED  | one box lit, waiting for a hit or timeout
// S_RESULT | one cycle: result pulse out, round counter advances
// S_DONE   | game over, counters held, waiting for a start edge
module mole_round_ctrl #(
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int NUM_ROUNDS     = 16,
  parameter int CNT_W          = 26
) (
  input  logic             clk,
  input  logic             resetn,
  mole_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GAP    = 3'd1,
    S_ARMED  = 3'd2,
    S_RESULT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Down-counters load N-1 and expire on the terminal count of zero,
  // so a phase lasts exactly N cycles.
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       RND_END = 8'(NUM_ROUNDS);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Reset synchronizer: assert immediately, release on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       active_q, active_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       misses_q, misses_d;
  logic [7:0]       round_q, round_d;
  logic             hit_ok_q, hit_ok_d;
  logic             miss_q, miss_d;
  logic             start_q;
  logic [3:0]       hit_q;

  logic             start_rise;
  logic [3:0]       hit_rise;
  logic [7:0]       round_inc;
  logic [1:0]       arm_box;

  assign start_rise = bus.start & ~start_q;
  assign hit_rise   = bus.hit & ~hit_q;
  assign round_inc  = round_q + 8'd1;

`ifdef MOLE_NO_REPEAT_EN
  logic [1:0] prev_box_q, prev_box_d;
  logic       prev_vld_q, prev_vld_d;

  always_comb begin
    arm_box = bus.box_in;
    if (prev_vld_q && (bus.box_in == prev_box_q)) arm_box = bus.box_in + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_box_q <= 2'd0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_box_q <= prev_box_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  assign arm_box = bus.box_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      active_q <= 2'd0;
      score_q  <= 8'd0;
      misses_q <= 8'd0;
      round_q  <= 8'd0;
      hit_ok_q <= 1'b0;
      miss_q   <= 1'b0;
      start_q  <= 1'b0;
      hit_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      score_q  <= score_d;
      misses_q <= misses_d;
      round_q  <= round_d;
      hit_ok_q <= hit_ok_d;
      miss_q   <= miss_d;
      start_q  <= bus.start;
      hit_q    <= bus.hit;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    score_d  = score_q;
    misses_d = misses_q;
    round_d  = round_q;
    hit_ok_d = 1'b0;
    miss_d   = 1'b0;
`ifdef MOLE_NO_REPEAT_EN
    prev_box_d = prev_box_q;
    prev_vld_d = prev_vld_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          score_d  = 8'd0;
          misses_d = 8'd0;
          round_d  = 8'd0;
          cnt_d    = GAP_LD;
          state_d  = S_GAP;
`ifdef MOLE_NO_REPEAT_EN
          prev_vld_d = 1'b0;
`endif
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          active_d = arm_box;
          cnt_d    = TO_LD;
          state_d  = S_ARMED;
`ifdef MOLE_NO_REPEAT_EN
          prev_box_d = arm_box;
          prev_vld_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_ARMED: begin
        // The lit box wins even if other boxes rise in the same cycle.
        if (hit_rise[active_q]) begin
          score_d  = sat_inc(score_q);
          hit_ok_d = 1'b1;
          state_d  = S_RESULT;
        end else if (|hit_rise) begin
          misses_d = sat_inc(misses_q);
          miss_d   = 1'b1;
          state_d  = S_RESULT;
        end else if (cnt_q == '0) begin
          misses_d = sat_inc(misses_q);
          miss_d   = 1'b1;
          state_d  = S_RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RESULT: begin
        round_d = round_inc;
        if (round_inc == RND_END) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = GAP_LD;
          state_d = S_GAP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.box_led   = (state_q == S_ARMED) ? (4'b0001 << active_q) : 4'b0000;
  assign bus.score     = score_q;
  assign bus.misses    = misses_q;
  assign bus.round_num = round_q;
  assign bus.hit_ok    = hit_ok_q;
  assign bus.miss      = miss_q;
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mole_round_ctrl.sv
module tb_mole_round_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mole_round_ctrl_if bus ();

  mole_round_ctrl #(
    .GAP_CYCLES(4), .TIMEOUT_CYCLES(8), .NUM_ROUNDS(3), .CNT_W(26)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct {
    logic [1:0] box;
    logic [3:0] hit;
    int         dly;        // ARMED cycle on which hit is raised, 0 = none
    logic [3:0] led;
    logic       ok;
    logic       ms;
    logic [7:0] sc;
    logic [7:0] mi;
    logic [7:0] rnd;
  } vec_t;

  typedef struct {
    logic       ok;
    logic       ms;
    logic [7:0] sc;
    logic [7:0] mi;
  } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every result pulse pops one expected record.
  always @(negedge clk) begin
    if (bus.hit_ok || bus.miss) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse hit_ok=%0b miss=%0b required=none", bus.hit_ok, bus.miss);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("pulse_hit_ok", bus.hit_ok, e.ok);
        chk("pulse_miss", bus.miss, e.ms);
        chk("pulse_score", bus.score, e.sc);
        chk("pulse_misses", bus.misses, e.mi);
        chk("pulse_led_dark", bus.box_led, 4'b0000);
      end
    end
  end

  task automatic wait_led(output bit ok);
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.box_led != 4'b0000) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic start_game();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_done_low", bus.done, 1'b0);
    chk("start_score_clr", bus.score, 8'd0);
    chk("start_misses_clr", bus.misses, 8'd0);
    chk("start_round_clr", bus.round_num, 8'd0);
  endtask

  task automatic run_round(input vec_t v);
    bit ok;
    int cnt;
    bus.box_in = v.box;
    wait_led(ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL arm_timeout led=%0h required=%0h", bus.box_led, v.led);
      return;
    end
    chk("armed_led", bus.box_led, v.led);
    if (v.dly > 0) begin
      repeat (v.dly - 1) tick();
      sbq.push_back('{v.ok, v.ms, v.sc, v.mi});
      bus.hit = v.hit;
      tick();
      bus.hit = 4'b0000;
    end else begin
      sbq.push_back('{v.ok, v.ms, v.sc, v.mi});
      cnt = 1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.box_led == 4'b0000) break;
        cnt++;
      end
      chk("timeout_lit_cycles", cnt, 8);
    end
    tick();
    chk("round_num", bus.round_num, v.rnd);
    chk("post_round_led", bus.box_led, 4'b0000);
  endtask

  task automatic check_done(input logic [7:0] sc, input logic [7:0] mi);
    chk("done_high", bus.done, 1'b1);
    chk("done_led", bus.box_led, 4'b0000);
    chk("done_score", bus.score, sc);
    chk("done_misses", bus.misses, mi);
    chk("done_round", bus.round_num, 8'd3);
  endtask

  initial begin
    bit ok;
    //            box    hit      dly led      ok    ms    sc    mi    rnd
    vecs[0] = '{2'd2, 4'b0100, 3, 4'b0100, 1'b1, 1'b0, 8'd1, 8'd0, 8'd1};
    vecs[1] = '{2'd1, 4'b0000, 0, 4'b0010, 1'b0, 1'b1, 8'd1, 8'd1, 8'd2};
    vecs[2] = '{2'd3, 4'b0001, 1, 4'b1000, 1'b0, 1'b1, 8'd1, 8'd2, 8'd3};
    vecs[3] = '{2'd0, 4'b0011, 2, 4'b0001, 1'b1, 1'b0, 8'd1, 8'd0, 8'd1};
    vecs[4] = '{2'd3, 4'b1000, 5, 4'b1000, 1'b1, 1'b0, 8'd2, 8'd0, 8'd2};
    vecs[5] = '{2'd1, 4'b0010, 1, 4'b0010, 1'b1, 1'b0, 8'd1, 8'd0, 8'd1};
`ifdef MOLE_NO_REPEAT_EN
    vecs[6] = '{2'd1, 4'b0100, 1, 4'b0100, 1'b1, 1'b0, 8'd2, 8'd0, 8'd2};
`else
    vecs[6] = '{2'd1, 4'b0010, 1, 4'b0010, 1'b1, 1'b0, 8'd2, 8'd0, 8'd2};
`endif
    vecs[7] = '{2'd1, 4'b0010, 1, 4'b0010, 1'b1, 1'b0, 8'd3, 8'd0, 8'd3};

    // Reset with arbitrary inputs
    bus.start = 1'b1;
    bus.hit = 4'hF;
    bus.box_in = 2'd3;
    repeat (3) tick();
    chk("rst_led", bus.box_led, 4'b0000);
    chk("rst_score", bus.score, 8'd0);
    chk("rst_misses", bus.misses, 8'd0);
    chk("rst_round", bus.round_num, 8'd0);
    chk("rst_hit_ok", bus.hit_ok, 1'b0);
    chk("rst_miss", bus.miss, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    bus.start = 1'b0;
    bus.hit = 4'h0;
    resetn = 1'b1;
    repeat (20) tick();
    chk("idle_led", bus.box_led, 4'b0000);
    chk("idle_done", bus.done, 1'b0);

    // Game 1: correct hit, timeout, wrong box
    start_game();
    for (int i = 0; i < 3; i++) run_round(vecs[i]);
    check_done(8'd1, 8'd2);
    bus.hit = 4'hF;
    tick();
    bus.hit = 4'h0;
    repeat (3) tick();
    check_done(8'd1, 8'd2);

    // Game 2: simultaneous hits, late hit, hit held across arm
    start_game();
    for (int i = 3; i < 5; i++) run_round(vecs[i]);
    bus.box_in = 2'd0;
    bus.hit = 4'b0001;
    wait_led(ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL hold_arm_timeout led=%0h required=1", bus.box_led);
    end
    chk("hold_led", bus.box_led, 4'b0001);
    tick();
    tick();
    bus.hit = 4'b0000;
    tick();
    sbq.push_back('{1'b1, 1'b0, 8'd3, 8'd0});
    bus.hit = 4'b0001;
    tick();
    bus.hit = 4'b0000;
    tick();
    check_done(8'd3, 8'd0);

    // Game 3: box_in held at 1
    start_game();
    for (int i = 5; i < 8; i++) run_round(vecs[i]);
    check_done(8'd3, 8'd0);

    // Reset while holding results
    resetn = 1'b0;
    #1;
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_score", bus.score, 8'd0);
    chk("midrst_round", bus.round_num, 8'd0);
    tick();
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
